// File: rtl/carry_skip_block_reg_pkg.sv
// Shared helpers for the carry-skip adder block.
// Holds the skip-mux selection so every block in a chain bypasses the same way.
package carry_skip_block_reg_pkg;

  // When every bit propagates, the block's carry-in passes straight through.
  function automatic logic skip_select(
    input logic all_prop,
    input logic carry_in,
    input logic ripple_carry
  );
    return all_prop ? carry_in : ripple_carry;
  endfunction

endpackage

// File: rtl/carry_skip_block_reg_full_adder.sv
// One-bit full adder: a single stage of the block's ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_p;
  logic w_g;

  assign w_p = a ^ b;
  assign w_g = a & b;
  assign s   = w_p ^ ci;
  assign co  = w_g | (w_p & ci);

endmodule

// File: rtl/carry_skip_block_reg.sv
// One WIDTH-bit carry-skip adder block with registered sum, ripple carry and skip carry.
// block_carry_out feeds the next block's cin when building wide carry-skip adders.
module carry_skip_block_reg
  import carry_skip_block_reg_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             block_carry_out
);

  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH:0]   w_c;
  logic             w_skip_co;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_block_carry_out;

  assign w_p    = a ^ b;
  assign w_c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (w_c[i]),
      .s  (w_s[i]),
      .co (w_c[i+1])
    );
  end

  // The skip carry is taken from the mux, never from cout, so the two stay independent.
  assign w_skip_co = skip_select(&w_p, cin, w_c[WIDTH]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid       <= 1'b0;
      r_sum             <= '0;
      r_cout            <= 1'b0;
      r_block_carry_out <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum             <= w_s;
        r_cout            <= w_c[WIDTH];
        r_block_carry_out <= w_skip_co;
      end
    end
  end

  assign out_valid       = r_out_valid;
  assign sum             = r_sum;
  assign cout            = r_cout;
  assign block_carry_out = r_block_carry_out;

endmodule

// File: tb/tb_carry_skip_block_reg.sv
// Directed and table-driven checks of carry_skip_block_reg at WIDTH=1, 4 and 8.
module tb_carry_skip_block_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=1 instance
  logic       w1_iv = 1'b0, w1_a = 1'b0, w1_b = 1'b0, w1_cin = 1'b0;
  logic       w1_ov, w1_s, w1_co, w1_bco;
  // WIDTH=4 instance
  logic       w4_iv = 1'b0, w4_cin = 1'b0;
  logic [3:0] w4_a = '0, w4_b = '0;
  logic       w4_ov, w4_co, w4_bco;
  logic [3:0] w4_s;
  // WIDTH=8 instance
  logic       w8_iv = 1'b0, w8_cin = 1'b0;
  logic [7:0] w8_a = '0, w8_b = '0;
  logic       w8_ov, w8_co, w8_bco;
  logic [7:0] w8_s;

  carry_skip_block_reg #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(w1_iv), .a(w1_a), .b(w1_b), .cin(w1_cin),
    .out_valid(w1_ov), .sum(w1_s), .cout(w1_co), .block_carry_out(w1_bco)
  );
  carry_skip_block_reg #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(w4_iv), .a(w4_a), .b(w4_b), .cin(w4_cin),
    .out_valid(w4_ov), .sum(w4_s), .cout(w4_co), .block_carry_out(w4_bco)
  );
  carry_skip_block_reg #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(w8_iv), .a(w8_a), .b(w8_b), .cin(w8_cin),
    .out_valid(w8_ov), .sum(w8_s), .cout(w8_co), .block_carry_out(w8_bco)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  typedef struct {
    logic a, b, cin;
    logic s, co, bco;
  } vec1_t;

  typedef struct {
    logic [3:0] a, b;
    logic       cin;
    logic [3:0] s;
    logic       co, bco;
  } vec4_t;

  vec1_t t1[8];
  vec4_t t4[4];

  // Drive one W4 vector at a falling edge; results are checked at the next falling edge.
  task automatic w4_step(input logic [3:0] a, input logic [3:0] b, input logic cin,
                         input logic [3:0] es, input logic eco, input logic ebco, input string tag);
    w4_iv = 1'b1; w4_a = a; w4_b = b; w4_cin = cin;
    @(negedge clk);
    check({tag, ".ov"},  {31'd0, w4_ov}, 32'd1);
    check({tag, ".sum"}, {28'd0, w4_s},  {28'd0, es});
    check({tag, ".co"},  {31'd0, w4_co}, {31'd0, eco});
    check({tag, ".bco"}, {31'd0, w4_bco}, {31'd0, ebco});
  endtask

  initial begin
    t1[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    t1[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    t1[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    t1[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    t1[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    t1[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    t1[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    t1[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    t4[0] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1};
    t4[1] = '{4'hF, 4'h0, 1'b0, 4'hF, 1'b0, 1'b0};
    t4[2] = '{4'h9, 4'h8, 1'b0, 4'h1, 1'b1, 1'b1};
    t4[3] = '{4'h3, 4'h4, 1'b0, 4'h7, 1'b0, 1'b0};

    // Reset held for two cycles
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst.w4.ov",  {31'd0, w4_ov},  32'd0);
    check("rst.w4.sum", {28'd0, w4_s},   32'd0);
    check("rst.w4.co",  {31'd0, w4_co},  32'd0);
    check("rst.w4.bco", {31'd0, w4_bco}, 32'd0);
    check("rst.w1.all", {28'd0, w1_ov, w1_s, w1_co, w1_bco}, 32'd0);
    check("rst.w8.all", {21'd0, w8_ov, w8_s, w8_co, w8_bco}, 32'd0);

    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rel.w4.all", {25'd0, w4_ov, w4_s, w4_co, w4_bco}, 32'd0);

    // WIDTH=1 exhaustive, one vector per cycle
    for (int i = 0; i < 8; i++) begin
      w1_iv = 1'b1; w1_a = t1[i].a; w1_b = t1[i].b; w1_cin = t1[i].cin;
      @(negedge clk);
      check($sformatf("w1[%0d].ov", i),  {31'd0, w1_ov},  32'd1);
      check($sformatf("w1[%0d].sum", i), {31'd0, w1_s},   {31'd0, t1[i].s});
      check($sformatf("w1[%0d].co", i),  {31'd0, w1_co},  {31'd0, t1[i].co});
      check($sformatf("w1[%0d].bco", i), {31'd0, w1_bco}, {31'd0, t1[i].bco});
    end
    w1_iv = 1'b0;

    // WIDTH=4 skip and generate paths
    for (int i = 0; i < 4; i++)
      w4_step(t4[i].a, t4[i].b, t4[i].cin, t4[i].s, t4[i].co, t4[i].bco, $sformatf("w4[%0d]", i));

    // Three back-to-back results, then hold with garbage on the inputs
    w4_step(4'h1, 4'h2, 1'b0, 4'h3, 1'b0, 1'b0, "b2b0");
    w4_step(4'h5, 4'h6, 1'b0, 4'hB, 1'b0, 1'b0, "b2b1");
    w4_step(4'h7, 4'h8, 1'b1, 4'h0, 1'b1, 1'b1, "b2b2");
    w4_iv = 1'b0; w4_a = 4'hx; w4_b = 4'hx; w4_cin = 1'bx;
    repeat (2) begin
      @(negedge clk);
      check("hold.ov",  {31'd0, w4_ov},  32'd0);
      check("hold.sum", {28'd0, w4_s},   32'd0);
      check("hold.co",  {31'd0, w4_co},  32'd1);
      check("hold.bco", {31'd0, w4_bco}, 32'd1);
    end

    // Reset coinciding with a valid input drops it
    w4_step(4'h9, 4'h8, 1'b1, 4'h2, 1'b1, 1'b1, "pre_rst");
    rst = 1'b1; w4_iv = 1'b1; w4_a = 4'hF; w4_b = 4'hF; w4_cin = 1'b1;
    @(negedge clk);
    rst = 1'b0; w4_iv = 1'b0;
    check("midrst.all", {25'd0, w4_ov, w4_s, w4_co, w4_bco}, 32'd0);
    @(negedge clk);
    check("midrst.stay", {25'd0, w4_ov, w4_s, w4_co, w4_bco}, 32'd0);

    // WIDTH=8 random sweep plus both corners
    for (int i = 0; i < 40; i++) begin
      logic [8:0] exp_full;
      if (i == 0) begin
        w8_a = 8'hFF; w8_b = 8'h00; w8_cin = 1'b1;
      end else if (i == 1) begin
        w8_a = 8'hFF; w8_b = 8'hFF; w8_cin = 1'b0;
      end else begin
        w8_a = 8'($urandom); w8_b = 8'($urandom); w8_cin = 1'($urandom);
      end
      w8_iv = 1'b1;
      exp_full = {1'b0, w8_a} + {1'b0, w8_b} + {8'd0, w8_cin};
      @(negedge clk);
      check($sformatf("w8[%0d].ov", i),  {31'd0, w8_ov}, 32'd1);
      check($sformatf("w8[%0d].sum", i), {24'd0, w8_s},  {24'd0, exp_full[7:0]});
      check($sformatf("w8[%0d].co", i),  {31'd0, w8_co}, {31'd0, exp_full[8]});
      check($sformatf("w8[%0d].bco", i), {31'd0, w8_bco}, {31'd0, exp_full[8]});
    end
    w8_iv = 1'b0;
    @(negedge clk);
    check("w8.idle.ov", {31'd0, w8_ov}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
